jtdd_irq_ctrl: RTL and testbench

//  Parametrised interrupt controller for the main/sub CPUs of the DD-family cores.

---
 rtl/jtdd_irq_ctrl.sv | 87 ++++++++
 tb/tb_jtdd_irq_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/jtdd_irq_ctrl.sv
// Interrupt controller for the DD-family main/sub CPUs: CH channels with edge/level mode,
// polarity, mask and software set/clear. Define JTDD_IRQ_MISSED_EN for missed-edge counters.
module jtdd_irq_ctrl #(
   parameter int            CH   = 4,
   parameter logic [CH-1:0] EDGE = {CH{1'b1}},
   parameter logic [CH-1:0] POL  = {CH{1'b1}}
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic [CH-1:0] src,
   input  logic          cs,
   input  logic          rnw,
   input  logic [2:0]    addr,
   input  logic [7:0]    din,
   output logic [7:0]    dout,
   output logic [CH-1:0] irq_n
);

   // Unimplemented channel bits read back as 1
   localparam logic [7:0] PAD = 8'hFF << CH;

   logic [CH-1:0] a, a_d, ev, pend, mask, clr_m, set_m;
   logic          wr;
   logic          unused_din;

   assign a          = src ~^ POL;
   assign ev         = a & ~a_d & EDGE;
   assign wr         = cs & ~rnw & cen;
   assign clr_m      = {CH{wr && addr == 3'd0}} & din[CH-1:0];
   assign set_m      = {CH{wr && addr == 3'd2}} & din[CH-1:0];
   assign irq_n      = ~(pend & mask);
   assign unused_din = ^din;

   // a_d resets to active so a source already active at release is not an edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_d  <= {CH{1'b1}};
         pend <= '0;
         mask <= {CH{1'b1}};
      end else begin
         a_d <= a;
         for (int i = 0; i < CH; i++) begin
            // An arriving edge beats a same-cycle software clear
            pend[i] <= EDGE[i] ? (ev[i] | set_m[i] | (pend[i] & ~clr_m[i])) : a[i];
         end
         if (wr && addr == 3'd1) mask <= din[CH-1:0];
      end
   end

`ifdef JTDD_IRQ_MISSED_EN
   logic [31:0] cnt_all;

   for (genvar i = 0; i < 8; i++) begin : g_cnt
      if (i < CH) begin : g_on
         logic [3:0] cnt;
         logic       inc, clr;
         assign inc = ev[i] & pend[i];
         assign clr = wr && addr == 3'(4 + i / 2);
         always_ff @(posedge clk or posedge rst) begin
            if (rst)                      cnt <= 4'd0;
            else if (clr)                 cnt <= {3'd0, inc};
            else if (inc && cnt != 4'hF)  cnt <= cnt + 4'd1;
         end
         assign cnt_all[4*i +: 4] = cnt;
      end else begin : g_off
         assign cnt_all[4*i +: 4] = 4'hF;
      end
   end
`endif

   always_comb begin
      dout = 8'hFF;
      case (addr)
         3'd0:    dout = PAD | 8'(pend);
         3'd1:    dout = PAD | 8'(mask);
         3'd2:    dout = PAD | 8'(pend & mask);
         3'd3:    dout = PAD | 8'(a);
`ifdef JTDD_IRQ_MISSED_EN
         default: dout = cnt_all[{addr[1:0], 3'b000} +: 8];
`else
         default: dout = 8'hFF;
`endif
      endcase
   end

endmodule

// File: tb/tb_jtdd_irq_ctrl.sv
// Bench for jtdd_irq_ctrl: an all-edge instance and a mixed edge/level instance,
// driven from a vector table plus hand sequences for counters and mid-operation reset.
module tb_jtdd_irq_ctrl;

   logic       clk, rst, cen, rnw;
   logic [2:0] addr;
   logic [7:0] din;
   logic [3:0] src_m, src_l, irq_m, irq_l;
   logic       cs_m, cs_l;
   logic [7:0] dout_m, dout_l;

   int n_tests = 0;
   int n_fail  = 0;

   logic [11:0] exp_q[$];

`ifdef JTDD_IRQ_MISSED_EN
   localparam logic [7:0] C_IDLE = 8'h00, C_SAT = 8'hF0, C_CH0 = 8'h01, C_ONE = 8'h10;
`else
   localparam logic [7:0] C_IDLE = 8'hFF, C_SAT = 8'hFF, C_CH0 = 8'hFF, C_ONE = 8'hFF;
`endif

   jtdd_irq_ctrl #(.CH(4), .EDGE(4'b1111), .POL(4'b1111)) u_main (
      .clk(clk), .rst(rst), .cen(cen), .src(src_m), .cs(cs_m), .rnw(rnw),
      .addr(addr), .din(din), .dout(dout_m), .irq_n(irq_m)
   );

   jtdd_irq_ctrl #(.CH(4), .EDGE(4'b1101), .POL(4'b1101)) u_lvl (
      .clk(clk), .rst(rst), .cen(cen), .src(src_l), .cs(cs_l), .rnw(rnw),
      .addr(addr), .din(din), .dout(dout_l), .irq_n(irq_l)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         dut;
      logic [3:0] src;
      logic       cs, rnw, cen;
      logic [2:0] addr;
      logic [7:0] din;
      logic [7:0] exp_dout;
      logic [3:0] exp_irq;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit dut, logic [3:0] s, logic c, logic r, logic e,
                               logic [2:0] a, logic [7:0] d, logic [7:0] ed, logic [3:0] ei);
      vec_t v;
      v.dut = dut; v.src = s; v.cs = c; v.rnw = r; v.cen = e;
      v.addr = a; v.din = d; v.exp_dout = ed; v.exp_irq = ei;
      return v;
   endfunction

   function automatic vec_t rd(bit dut, logic [3:0] s, logic [2:0] a, logic [7:0] ed, logic [3:0] ei);
      return mk(dut, s, 1'b1, 1'b1, 1'b1, a, 8'h00, ed, ei);
   endfunction

   function automatic vec_t wrv(bit dut, logic [3:0] s, logic e, logic [2:0] a, logic [7:0] d,
                                logic [7:0] ed, logic [3:0] ei);
      return mk(dut, s, 1'b1, 1'b0, e, a, d, ed, ei);
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // driver: apply one vector across a clock edge, then compare against the scoreboard
   task automatic apply_vec(input vec_t v, input string tag);
      logic [7:0] e_d;
      logic [3:0] e_i;
      exp_q.push_back({v.exp_dout, v.exp_irq});
      if (v.dut) begin src_l = v.src; cs_l = v.cs; cs_m = 1'b0; end
      else       begin src_m = v.src; cs_m = v.cs; cs_l = 1'b0; end
      rnw = v.rnw; cen = v.cen; addr = v.addr; din = v.din;
      @(posedge clk);
      #1;
      cs_m = 1'b0;
      cs_l = 1'b0;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         {e_d, e_i} = exp_q.pop_front();
         check({tag, " dout"}, v.dut ? dout_l : dout_m, e_d);
         check({tag, " irq_n"}, {4'h0, v.dut ? irq_l : irq_m}, {4'h0, e_i});
      end
   endtask

   initial begin
      // main instance: all edge, active high
      tbl.push_back(rd (0, 4'b1110, 3'd3, 8'hFE, 4'hF));          // drop src[0], a visible
      tbl.push_back(rd (0, 4'b1111, 3'd0, 8'hF1, 4'hE));          // rise -> pend[0]
      tbl.push_back(rd (0, 4'b1110, 3'd0, 8'hF1, 4'hE));          // drop keeps pend
      tbl.push_back(wrv(0, 4'b1111, 1, 3'd0, 8'h01, 8'hF1, 4'hE)); // clear vs event: set wins
      tbl.push_back(wrv(0, 4'b1111, 1, 3'd0, 8'h01, 8'hF0, 4'hF)); // clear, no event
      tbl.push_back(wrv(0, 4'b1111, 1, 3'd1, 8'h0E, 8'hFE, 4'hF)); // mask ch0
      tbl.push_back(rd (0, 4'b1110, 3'd0, 8'hF0, 4'hF));
      tbl.push_back(rd (0, 4'b1111, 3'd0, 8'hF1, 4'hF));          // pending but masked
      tbl.push_back(rd (0, 4'b1111, 3'd2, 8'hF0, 4'hF));
      tbl.push_back(wrv(0, 4'b1111, 1, 3'd1, 8'h0F, 8'hFF, 4'hE)); // unmask -> irq at once
      tbl.push_back(wrv(0, 4'b1111, 1, 3'd2, 8'h04, 8'hF5, 4'hA)); // software set ch2
      tbl.push_back(wrv(0, 4'b1111, 0, 3'd0, 8'h0F, 8'hF5, 4'hA)); // cen=0 clear ignored
      tbl.push_back(wrv(0, 4'b1111, 0, 3'd1, 8'h00, 8'hFF, 4'hA)); // cen=0 mask ignored
      tbl.push_back(wrv(0, 4'b1111, 1, 3'd0, 8'h0F, 8'hF0, 4'hF));
      tbl.push_back(mk (0, 4'b1111, 0, 0, 1, 3'd2, 8'h08, 8'hF0, 4'hF)); // cs=0 write ignored
      tbl.push_back(mk (0, 4'b1111, 1, 1, 1, 3'd2, 8'h08, 8'hF0, 4'hF)); // read, no side effect
      tbl.push_back(rd (0, 4'b1111, 3'd7, 8'hFF, 4'hF));          // channels >= CH
      tbl.push_back(rd (0, 4'b1111, 3'd5, C_IDLE, 4'hF));
      tbl.push_back(rd (0, 4'b1111, 3'd4, C_CH0, 4'hF));          // ch0 missed one edge
      // level instance: ch1 level, active low
      tbl.push_back(rd (1, 4'b1101, 3'd0, 8'hF2, 4'hD));
      tbl.push_back(wrv(1, 4'b1101, 1, 3'd0, 8'h02, 8'hF2, 4'hD)); // clear ignored
      tbl.push_back(rd (1, 4'b1111, 3'd0, 8'hF0, 4'hF));          // follows source
      tbl.push_back(wrv(1, 4'b1111, 1, 3'd2, 8'h02, 8'hF0, 4'hF)); // set ignored
      tbl.push_back(rd (1, 4'b1110, 3'd3, 8'hFC, 4'hF));
      tbl.push_back(rd (1, 4'b1111, 3'd0, 8'hF1, 4'hE));          // edge ch0 still works

      rst = 1'b1; cen = 1'b1; rnw = 1'b1; addr = 3'd0; din = 8'h00;
      src_m = 4'hF; src_l = 4'hF; cs_m = 1'b0; cs_l = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset irq_n main", {4'h0, irq_m}, 8'h0F);
      check("reset irq_n lvl", {4'h0, irq_l}, 8'h0F);
      check("reset pend", dout_m, 8'hF0);
      addr = 3'd1; #1;
      check("reset mask", dout_m, 8'hFF);
      addr = 3'd3; #1;
      check("reset levels", dout_m, 8'hFF);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < tbl.size(); i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

      // missed-edge counters on ch3
      apply_vec(wrv(0, 4'b1111, 1, 3'd2, 8'h08, 8'hF8, 4'h7), "set ch3");
      for (int k = 0; k < 20; k++) begin
         apply_vec(rd(0, 4'b0111, 3'd0, 8'hF8, 4'h7), $sformatf("miss drop%0d", k));
         apply_vec(rd(0, 4'b1111, 3'd0, 8'hF8, 4'h7), $sformatf("miss rise%0d", k));
      end
      apply_vec(rd (0, 4'b1111, 3'd5, C_SAT, 4'h7), "cnt saturated");
      apply_vec(wrv(0, 4'b1111, 1, 3'd5, 8'h5A, C_IDLE, 4'h7), "cnt cleared");
      apply_vec(rd (0, 4'b0111, 3'd5, C_IDLE, 4'h7), "cnt drop");
      apply_vec(wrv(0, 4'b1111, 1, 3'd5, 8'h00, C_ONE, 4'h7), "cnt clear+inc");

      // reset in the middle of operation
      apply_vec(wrv(0, 4'b1111, 1, 3'd1, 8'h05, 8'hF5, 4'hF), "mask 05");
      apply_vec(rd (0, 4'b1011, 3'd0, 8'hF8, 4'hF), "pre-reset pend");
      addr = 3'd0;
      src_m = 4'b1111;
      #2 rst = 1'b1;
      #1;
      check("async reset irq_n", {4'h0, irq_m}, 8'h0F);
      check("async reset pend", dout_m, 8'hF0);
      addr = 3'd1; #1;
      check("async reset mask", dout_m, 8'hFF);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      apply_vec(rd(0, 4'b1111, 3'd0, 8'hF0, 4'hF), "edge in reset dropped");
      apply_vec(rd(0, 4'b1111, 3'd5, C_IDLE, 4'hF), "cnt after reset");

      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard leftover: got %0d entries, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
